// File: rtl/weight_fetch_responder_if.sv
// Weight-fetch handshake and weight-SRAM read port bundled together.
// slave: the responder. master: the scheduler/SRAM side.
interface weight_fetch_responder_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 11
);
    logic              weight_req;
    logic [ADDR_W-1:0] weight_base;
    logic [CNT_W-1:0]  weight_count;
    logic              weight_grant;
    logic              weight_valid;
    logic [DATA_W-1:0] weight_data;
    logic              weight_done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_ready;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  weight_req, weight_base, weight_count, mem_rd_ready, mem_rd_data,
        output weight_grant, weight_valid, weight_data, weight_done, mem_rd_en, mem_addr
    );

    modport master (
        output weight_req, weight_base, weight_count, mem_rd_ready, mem_rd_data,
        input  weight_grant, weight_valid, weight_data, weight_done, mem_rd_en, mem_addr
    );
endinterface

// File: rtl/weight_fetch_responder.sv
// Weight-fetch responder: grants one request at a time, streams count
// consecutive SRAM words as weight_valid beats, then pulses weight_done.
// Optional perf counters (perf_bursts, perf_stall) when WFETCH_PERF_EN is defined.
module weight_fetch_responder #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 128,
    parameter int CNT_W   = 11,
    parameter int MEM_LAT = 2
) (
    input  logic CLK,
    input  logic RESET,
    weight_fetch_responder_if.slave bus,
    output logic busy
`ifdef WFETCH_PERF_EN
    ,
    output logic [15:0] perf_bursts,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  iss;
    logic [CNT_W-1:0]  rcv;
    logic [MEM_LAT:1]  vld_pipe;
    logic              acc;
    logic              beat;
    logic [CNT_W:0]    iss_nxt;
    logic [CNT_W:0]    rcv_nxt;

    assign bus.mem_rd_en = (state == S_ISSUE) && (iss < cnt);
    assign bus.mem_addr  = base + ADDR_W'(iss);
    assign busy          = (state != S_IDLE);
    assign acc           = bus.mem_rd_en && bus.mem_rd_ready;
    assign beat          = vld_pipe[MEM_LAT];
    assign iss_nxt       = {1'b0, iss} + (CNT_W+1)'(1);
    assign rcv_nxt       = {1'b0, rcv} + (CNT_W+1)'(1);

    // In-flight tracker: marks which SRAM cycles carry requested data.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= acc;
            for (int i = 2; i <= MEM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Control FSM with registered handshake outputs. The last beat moves us
    // to S_DONE so done lands exactly one cycle after it, already in S_IDLE,
    // which lets a held request be granted on that same edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state            <= S_IDLE;
            base             <= '0;
            cnt              <= '0;
            iss              <= '0;
            rcv              <= '0;
            bus.weight_grant <= 1'b0;
            bus.weight_valid <= 1'b0;
            bus.weight_data  <= '0;
            bus.weight_done  <= 1'b0;
        end else begin
            bus.weight_grant <= 1'b0;
            bus.weight_done  <= 1'b0;
            bus.weight_valid <= beat;
            if (beat) begin
                bus.weight_data <= bus.mem_rd_data;
                rcv             <= rcv_nxt[CNT_W-1:0];
            end
            case (state)
                S_IDLE: begin
                    if (bus.weight_req) begin
                        base             <= bus.weight_base;
                        cnt              <= bus.weight_count;
                        iss              <= '0;
                        rcv              <= '0;
                        bus.weight_grant <= 1'b1;
                        state            <= (bus.weight_count != '0) ? S_ISSUE : S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (acc) begin
                        iss <= iss_nxt[CNT_W-1:0];
                        if (iss_nxt == {1'b0, cnt}) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (beat && (rcv_nxt == {1'b0, cnt})) state <= S_DONE;
                end
                S_DONE: begin
                    bus.weight_done <= 1'b1;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WFETCH_PERF_EN
    // Saturating burst and SRAM-stall counters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perf_bursts <= '0;
            perf_stall  <= '0;
        end else begin
            if (bus.weight_done && (perf_bursts != '1)) perf_bursts <= perf_bursts + 16'd1;
            if (bus.mem_rd_en && !bus.mem_rd_ready && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_fetch_responder.sv
// Bench for weight_fetch_responder: schedule-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_weight_fetch_responder;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 128;
    localparam int CNT_W   = 11;
    localparam int MEM_LAT = 2;
    localparam int INF     = 1 << 30;

    logic CLK = 1'b0;
    logic RESET;
    logic busy;
`ifdef WFETCH_PERF_EN
    logic [15:0] perf_bursts;
    logic [31:0] perf_stall;
`endif

    weight_fetch_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    weight_fetch_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .MEM_LAT(MEM_LAT)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus),
        .busy(busy)
`ifdef WFETCH_PERF_EN
        ,
        .perf_bursts(perf_bursts),
        .perf_stall(perf_stall)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [DATA_W-1:0] sram_at[int];
    bit                rdy_q[$];

    // reference model state
    int                m_g = -1, m_d = -1, m_free = 0, m_cnt = 0, m_iss = 0;
    int                m_stall = 0, m_bursts = 0;
    logic [ADDR_W-1:0] m_base = '0;
    logic [DATA_W-1:0] beat_at[int];

    // observation logs for the directed checks
    int                log_g[$], log_d[$], log_v[$];
    logic [DATA_W-1:0] log_data[$];
    logic [ADDR_W-1:0] log_addr[$];

    int                t;
    logic              eg, ev, ed, er, eb;
    logic [ADDR_W-1:0] ea;

    function automatic logic [DATA_W-1:0] f(input logic [ADDR_W-1:0] a);
        return {4{13'h0, a}};
    endfunction

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        log_g.delete(); log_d.delete(); log_v.delete(); log_data.delete(); log_addr.delete();
    endtask

    // SRAM model and ready driver, updated just after each edge
    always @(posedge CLK) begin
        cyc++;
        #1;
        if (sram_at.exists(cyc)) begin
            bus.mem_rd_data = sram_at[cyc];
            sram_at.delete(cyc);
        end else begin
            bus.mem_rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        bus.mem_rd_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    end

    // Per-cycle compare against the schedule model
    always @(negedge CLK) begin
        t = cyc;
        if (!RESET) begin
            chk("rst_grant", bus.weight_grant, 0);
            chk("rst_valid", bus.weight_valid, 0);
            chk("rst_data",  bus.weight_data,  0);
            chk("rst_done",  bus.weight_done,  0);
            chk("rst_rd_en", bus.mem_rd_en,    0);
            chk("rst_busy",  busy,             0);
`ifdef WFETCH_PERF_EN
            chk("rst_perf_bursts", perf_bursts, 0);
            chk("rst_perf_stall",  perf_stall,  0);
`endif
            beat_at.delete();
            m_g = -1; m_d = -1; m_free = 0; m_cnt = 0; m_iss = 0; m_stall = 0; m_bursts = 0;
        end else begin
            eg = (t == m_g);
            ev = beat_at.exists(t);
            ed = (m_d >= 0) && (t == m_d);
            er = (m_g >= 0) && (t >= m_g) && (m_iss < m_cnt);
            eb = (m_g >= 0) && (t >= m_g) && ((m_d < 0) || (t < m_d));
            ea = m_base + ADDR_W'(m_iss);
            chk("grant", bus.weight_grant, eg);
            chk("valid", bus.weight_valid, ev);
            chk("done",  bus.weight_done,  ed);
            chk("rd_en", bus.mem_rd_en,    er);
            chk("busy",  busy,             eb);
            if (ev) chk("data", bus.weight_data, beat_at[t]);
            if (er) chk("addr", bus.mem_addr, ea);
`ifdef WFETCH_PERF_EN
            chk("perf_bursts", perf_bursts, m_bursts);
            chk("perf_stall",  perf_stall,  m_stall);
`endif
            if (bus.weight_grant) log_g.push_back(t);
            if (bus.weight_done)  log_d.push_back(t);
            if (bus.mem_rd_en)    log_addr.push_back(bus.mem_addr);
            if (bus.weight_valid) begin
                log_v.push_back(t);
                log_data.push_back(bus.weight_data);
            end
            if (bus.mem_rd_en && bus.mem_rd_ready) sram_at[t + MEM_LAT] = f(bus.mem_addr);
            if (er) begin
                if (bus.mem_rd_ready) begin
                    beat_at[t + MEM_LAT + 1] = f(ea);
                    m_iss++;
                    if (m_iss == m_cnt) begin
                        m_d    = t + MEM_LAT + 2;
                        m_free = m_d;
                    end
                end else begin
                    m_stall++;
                end
            end
            if (ed) m_bursts++;
            if (ev) beat_at.delete(t);
            if (bus.weight_req && (t >= m_free)) begin
                m_g    = t + 1;
                m_base = bus.weight_base;
                m_cnt  = int'(bus.weight_count);
                m_iss  = 0;
                m_d    = (m_cnt == 0) ? t + 2 : -1;
                m_free = (m_cnt == 0) ? t + 2 : INF;
            end
        end
    end

    task automatic wait_grant();
        int k = 0;
        do begin
            @(posedge CLK); #2; k++;
        end while (!bus.weight_grant && k < 60);
        if (!bus.weight_grant) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(posedge CLK); #2; k++;
        end while (!bus.weight_done && k < 100);
        if (!bus.weight_done) chk("done_timeout", 0, 1);
    endtask

    // Issue a request with a ready pattern (LSB = grant cycle), drop req at grant
    task automatic do_req(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c,
                          input logic [7:0] pat, input int npat);
        @(posedge CLK); #2;
        bus.weight_req   = 1'b1;
        bus.weight_base  = b;
        bus.weight_count = c;
        rdy_q.delete();
        for (int i = 0; i < npat; i++) rdy_q.push_back(pat[i]);
        wait_grant();
        bus.weight_req = 1'b0;
    endtask

    initial begin
        int k;
`ifdef WFETCH_PERF_EN
        int p0;
`endif
        RESET            = 1'b0;
        bus.weight_req   = 1'b0;
        bus.weight_base  = '0;
        bus.weight_count = '0;
        bus.mem_rd_ready = 1'b1;
        bus.mem_rd_data  = '0;
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b1;
        repeat (2) @(posedge CLK);

        // basic burst
        clear_logs();
        do_req(19'h00100, 11'd2, 8'h00, 0);
        wait_done();
        repeat (4) @(posedge CLK); #2;
        chk("basic_addr_n", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("basic_addr0", log_addr[0], 19'h00100);
            chk("basic_addr1", log_addr[1], 19'h00101);
        end
        if (log_v.size() == 2 && log_g.size() == 1 && log_d.size() == 1) begin
            chk("basic_lat",   log_v[0] - log_g[0], MEM_LAT + 1);
            chk("basic_data0", log_data[0], 128'h00000100_00000100_00000100_00000100);
            chk("basic_data1", log_data[1], 128'h00000101_00000101_00000101_00000101);
            chk("basic_done",  log_d[0] - log_v[1], 1);
        end else chk("basic_counts", log_v.size(), 2);

        // backpressure
        clear_logs();
`ifdef WFETCH_PERF_EN
        p0 = int'(perf_stall);
`endif
        do_req(19'h00200, 11'd4, 8'b00111001, 6);
        wait_done();
        repeat (2) @(posedge CLK); #2;
        chk("bp_addr_n", log_addr.size(), 6);
        if (log_addr.size() == 6) begin
            chk("bp_addr1", log_addr[1], 19'h00201);
            chk("bp_addr3", log_addr[3], 19'h00201);
            chk("bp_addr5", log_addr[5], 19'h00203);
        end
        chk("bp_beats", log_v.size(), 4);
        if (log_data.size() == 4) chk("bp_data3", log_data[3], 128'h00000203_00000203_00000203_00000203);
`ifdef WFETCH_PERF_EN
        chk("bp_perf_stall", int'(perf_stall) - p0, 2);
`endif

        // address wrap
        clear_logs();
        do_req(19'h7FFFE, 11'd3, 8'h00, 0);
        wait_done();
        repeat (2) @(posedge CLK); #2;
        chk("wrap_addr_n", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("wrap_addr1", log_addr[1], 19'h7FFFF);
            chk("wrap_addr2", log_addr[2], 19'h00000);
        end
        chk("wrap_beats", log_v.size(), 3);
        if (log_data.size() == 3) chk("wrap_data2", log_data[2], 128'h0);
        chk("wrap_done_n", log_d.size(), 1);

        // zero count
        clear_logs();
        do_req(19'h00050, 11'd0, 8'h00, 0);
        wait_done();
        repeat (3) @(posedge CLK); #2;
        if (log_g.size() == 1 && log_d.size() == 1) chk("zero_done_gap", log_d[0] - log_g[0], 1);
        else chk("zero_counts", log_d.size(), 1);
        chk("zero_reads", log_addr.size(), 0);
        chk("zero_beats", log_v.size(), 0);

        // reset mid-burst
        clear_logs();
        do_req(19'h00500, 11'd8, 8'h00, 0);
        k = 0;
        while (log_v.size() < 3 && k < 40) begin @(posedge CLK); #2; k++; end
        chk("mid_three_beats", log_v.size() >= 3, 1);
        RESET = 1'b0;
        #1;
        chk("mid_rst_valid", bus.weight_valid, 0);
        chk("mid_rst_data",  bus.weight_data,  0);
        chk("mid_rst_rd_en", bus.mem_rd_en,    0);
        chk("mid_rst_busy",  busy,             0);
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b1;
        clear_logs();
        repeat (8) @(posedge CLK); #2;
        chk("mid_no_valid", log_v.size(), 0);
        chk("mid_no_done",  log_d.size(), 0);
        do_req(19'h00600, 11'd1, 8'h00, 0);
        wait_done();
        @(posedge CLK); #2;
        chk("mid_after_beats", log_v.size(), 1);
        if (log_data.size() == 1) chk("mid_after_data", log_data[0], 128'h00000600_00000600_00000600_00000600);

        // back-to-back with req held
        clear_logs();
`ifdef WFETCH_PERF_EN
        p0 = int'(perf_bursts);
`endif
        @(posedge CLK); #2;
        bus.weight_req   = 1'b1;
        bus.weight_base  = 19'h00300;
        bus.weight_count = 11'd2;
        wait_grant();
        bus.weight_base  = 19'h00400;
        wait_done();
        wait_grant();
        bus.weight_req = 1'b0;
        wait_done();
        repeat (2) @(posedge CLK); #2;
        if (log_g.size() == 2 && log_d.size() == 2) chk("b2b_gap", log_g[1] - log_d[0], 1);
        else chk("b2b_counts", log_g.size(), 2);
        if (log_addr.size() == 4) chk("b2b_addr2", log_addr[2], 19'h00400);
        else chk("b2b_addr_n", log_addr.size(), 4);
`ifdef WFETCH_PERF_EN
        chk("b2b_perf_bursts", int'(perf_bursts) - p0, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
